// File: rtl/gate_pkg.sv
// Shared definitions for the matrix-converter gate-drive monitor.
package gate_pkg;

  localparam int AP = 5;
  localparam int AN = 4;
  localparam int BP = 3;
  localparam int BN = 2;
  localparam int CP = 1;
  localparam int CN = 0;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;
  localparam logic [1:0] SRC_C    = 2'b11;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_PAIR,
    CL_SINGLE,
    CL_OVERLAP,
    CL_ILLEGAL
  } pat_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEADY,
    ST_COMM,
    ST_FAULT
  } mon_state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ILLEGAL   = 3'd1;
  localparam logic [2:0] FC_MULTISTEP = 3'd2;
  localparam logic [2:0] FC_DWELL     = 3'd3;
  localparam logic [2:0] FC_DIRECTION = 3'd4;
  localparam logic [2:0] FC_BADENTRY  = 3'd5;

  function automatic logic [2:0] ones6(input logic [5:0] v);
    ones6 = '0;
    for (int i = 0; i < 6; i++) ones6 += {2'b00, v[i]};
  endfunction

endpackage

// File: rtl/gate_pattern_classify.sv
// Combinational decode of a gate word into pattern class,
// connected source and single-device current direction.
module gate_pattern_classify
  import gate_pkg::*;
(
  input  logic [5:0]  gate_in,
  output pat_class_e  pat_class,
  output logic [1:0]  src,
  output logic        dir
);

  logic [2:0] p_bits;
  logic [2:0] n_bits;
  logic [2:0] ones;

  always_comb begin
    p_bits    = {gate_in[AP], gate_in[BP], gate_in[CP]};
    n_bits    = {gate_in[AN], gate_in[BN], gate_in[CN]};
    ones      = ones6(gate_in);
    pat_class = CL_ILLEGAL;
    src       = SRC_NONE;
    dir       = |p_bits;
    if (gate_in == 6'b000000) begin
      pat_class = CL_ZERO;
    end else if (gate_in == 6'b110000) begin
      pat_class = CL_PAIR;
      src       = SRC_A;
    end else if (gate_in == 6'b001100) begin
      pat_class = CL_PAIR;
      src       = SRC_B;
    end else if (gate_in == 6'b000011) begin
      pat_class = CL_PAIR;
      src       = SRC_C;
    end else if (ones == 3'd1) begin
      pat_class = CL_SINGLE;
    end else if (ones == 3'd2 && (p_bits == 3'b000 || n_bits == 3'b000)) begin
      // both devices share a direction, so they sit on different phases
      pat_class = CL_OVERLAP;
    end
  end

endmodule

// File: rtl/gate_monitor.sv
// Independent four-step commutation checker for one output leg;
// latches Short on the first rule violation.
module gate_monitor
  import gate_pkg::*;
#(
  parameter int MAX_DWELL = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       gate_in,
  input  logic             CurrentSign,
  output logic             Short,
  output logic [2:0]       fault_code,
  output logic [1:0]       conn_src,
  output logic             commutating,
  output logic [CNT_W-1:0] comm_count
);

  pat_class_e cls;
  logic [1:0] pat_src;
  logic       pat_dir;

  gate_pattern_classify u_classify (
    .gate_in   (gate_in),
    .pat_class (cls),
    .src       (pat_src),
    .dir       (pat_dir)
  );

  mon_state_e       state_q, state_d;
  logic [5:0]       prev_q, prev_d;
  logic [3:0]       dwell_q, dwell_d;
  logic [1:0]       dep_q, dep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       src_q, src_d;
  logic             comm_q, comm_d;

  logic [4:0] dwell_inc;
  logic       multi;
  logic       prev_zero;
  logic       trans;
  logic [2:0] fc;

  always_comb begin
    dwell_inc = {1'b0, dwell_q} + 5'd1;
    multi     = ones6(gate_in ^ prev_q) > 3'd1;
    prev_zero = prev_q == 6'b000000;
    trans     = cls == CL_SINGLE || cls == CL_OVERLAP;
    fc        = FC_NONE;
    if (cls == CL_ILLEGAL)
      fc = FC_ILLEGAL;
    else if (multi && cls != CL_ZERO && !(prev_zero && cls == CL_PAIR))
      fc = FC_MULTISTEP;
    else if (prev_zero && trans)
      fc = FC_BADENTRY;
    else if (cls == CL_SINGLE && gate_in != prev_q && pat_dir != CurrentSign)
      fc = FC_DIRECTION;
    else if (state_q == ST_COMM && trans && dwell_inc > 5'(MAX_DWELL))
      fc = FC_DWELL;
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    dwell_d = dwell_q;
    dep_d   = dep_q;
    cnt_d   = cnt_q;
    short_d = short_q;
    code_d  = code_q;
    src_d   = src_q;
    comm_d  = comm_q;
    if (state_q != ST_FAULT) begin
      prev_d = gate_in;
      if (fc != FC_NONE) begin
        state_d = ST_FAULT;
        short_d = 1'b1;
        code_d  = fc;
        src_d   = SRC_NONE;
        comm_d  = 1'b0;
      end else begin
        unique case (cls)
          CL_PAIR: begin
            if (state_q == ST_COMM && pat_src != dep_q && cnt_q != '1)
              cnt_d = cnt_q + CNT_W'(1);
            state_d = ST_STEADY;
            src_d   = pat_src;
            comm_d  = 1'b0;
            dwell_d = '0;
          end
          CL_SINGLE, CL_OVERLAP: begin
            if (state_q == ST_STEADY) begin
              dep_d   = src_q;
              dwell_d = 4'd1;
            end else begin
              dwell_d = dwell_inc[3:0];
            end
            state_d = ST_COMM;
            src_d   = SRC_NONE;
            comm_d  = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
            comm_d  = 1'b0;
            dwell_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      dwell_q <= '0;
      dep_q   <= SRC_NONE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      code_q  <= FC_NONE;
      src_q   <= SRC_NONE;
      comm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      dep_q   <= dep_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      code_q  <= code_d;
      src_q   <= src_d;
      comm_q  <= comm_d;
    end
  end

  assign Short       = short_q;
  assign fault_code  = code_q;
  assign conn_src    = src_q;
  assign commutating = comm_q;
  assign comm_count  = cnt_q;

endmodule
